// File: rtl/frame_pattern_checker.sv
`timescale 1ns/1ps
// Video frame checker: measures frame/line geometry and compares pixel data
// against the test pattern selected by sel when the frame starts.
module frame_pattern_checker #(
   parameter int unsigned DVAL_HIGH = 640,
   parameter int unsigned ROW_COUNT = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fval,
   input  logic        lval,
   input  logic        dval,
   input  logic [7:0]  pix_value,
   input  logic [2:0]  sel,
   output logic        frame_done,
   output logic [15:0] frame_cnt,
   output logic [15:0] meas_lines,
   output logic [15:0] meas_pixels,
   output logic [15:0] pix_err_cnt,
   output logic        geom_err,
   output logic        proto_err
);

   localparam int unsigned COL_BAND  = (DVAL_HIGH / 8 > 0) ? DVAL_HIGH / 8 : 1;
   localparam int unsigned ROW_BAND  = (ROW_COUNT / 8 > 0) ? ROW_COUNT / 8 : 1;
   localparam logic [15:0] COL_LAST  = 16'(COL_BAND - 1);
   localparam logic [15:0] ROW_LAST  = 16'(ROW_BAND - 1);
   localparam logic [15:0] WIDTH_EXP = 16'(DVAL_HIGH);
   localparam logic [15:0] LINES_EXP = 16'(ROW_COUNT);
   localparam logic [15:0] SAT       = 16'hFFFF;

   typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, LINE = 2'd2} state_t;

   state_t      state_q;
   logic        fval_dly_q;
   logic        lval_dly_q;
   logic        armed_q;
   logic [2:0]  sel_q;
   logic [15:0] x_q;
   logic [15:0] y_q;
   logic [15:0] err_q;
   logic        geom_q;
   logic [15:0] col_q;
   logic [15:0] row_q;
   logic [2:0]  cb_q;
   logic [2:0]  rb_q;

   logic        fval_rise;
   logic        fval_fall;
   logic        lval_rise;
   logic        lval_fall;
   logic        pix_valid;
   logic        line_close;
   logic        mismatch;
   logic        cmp_on;
   logic        line_bad;
   logic        frame_geom_bad;
   logic [7:0]  exp_pix;
   logic [15:0] x_d;
   logic [15:0] y_d;
   logic [15:0] err_d;
   logic [15:0] lines_d;

   // armed_q blocks a frame start until fval has been seen low after reset
   assign fval_rise  = fval & ~fval_dly_q & armed_q;
   assign fval_fall  = ~fval & fval_dly_q;
   assign lval_rise  = lval & ~lval_dly_q;
   assign lval_fall  = ~lval & lval_dly_q;

   assign x_d        = (x_q == SAT)   ? x_q   : x_q + 16'd1;
   assign y_d        = (y_q == SAT)   ? y_q   : y_q + 16'd1;
   assign err_d      = (err_q == SAT) ? err_q : err_q + 16'd1;

   assign pix_valid  = (state_q == LINE) & fval & lval & dval;
   assign line_close = (state_q == LINE) & (lval_fall | fval_fall);
   assign mismatch   = pix_valid & cmp_on & (pix_value != exp_pix);
   assign line_bad   = (x_q != WIDTH_EXP);
   assign lines_d    = line_close ? y_d : y_q;
   assign frame_geom_bad = geom_q | (line_close & line_bad) | (lines_d != LINES_EXP);

   // Expected pixel for the current position; cb_q/rb_q are the checker band indices
   always_comb begin
      exp_pix = 8'h00;
      cmp_on  = 1'b0;
      case (sel_q)
         3'b000: begin
            exp_pix = 8'h00;
            cmp_on  = 1'b1;
         end
         3'b001: begin
            exp_pix = 8'hFF;
            cmp_on  = 1'b1;
         end
         3'b011: begin
            exp_pix = (cb_q[0] ^ rb_q[0]) ? 8'hFF : 8'h00;
            cmp_on  = 1'b1;
         end
         default: begin
            exp_pix = 8'h00;
            cmp_on  = 1'b0;
         end
      endcase
   end

   // Frame FSM, counters and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         fval_dly_q  <= 1'b0;
         lval_dly_q  <= 1'b0;
         armed_q     <= 1'b0;
         sel_q       <= 3'd0;
         x_q         <= 16'd0;
         y_q         <= 16'd0;
         err_q       <= 16'd0;
         geom_q      <= 1'b0;
         col_q       <= 16'd0;
         row_q       <= 16'd0;
         cb_q        <= 3'd0;
         rb_q        <= 3'd0;
         frame_done  <= 1'b0;
         frame_cnt   <= 16'd0;
         meas_lines  <= 16'd0;
         meas_pixels <= 16'd0;
         pix_err_cnt <= 16'd0;
         geom_err    <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         fval_dly_q <= fval;
         lval_dly_q <= lval;
         armed_q    <= armed_q | ~fval;
         frame_done <= 1'b0;
         if (dval && !pix_valid) begin
            proto_err <= 1'b1;
         end
         if (pix_valid) begin
            x_q <= x_d;
            if (col_q == COL_LAST) begin
               col_q <= 16'd0;
               if (cb_q != 3'd7) cb_q <= cb_q + 3'd1;
            end else begin
               col_q <= col_q + 16'd1;
            end
            if (mismatch) err_q <= err_d;
         end
         if (line_close) begin
            meas_pixels <= x_q;
            x_q         <= 16'd0;
            col_q       <= 16'd0;
            cb_q        <= 3'd0;
            y_q         <= y_d;
            if (line_bad) geom_q <= 1'b1;
            if (row_q == ROW_LAST) begin
               row_q <= 16'd0;
               if (rb_q != 3'd7) rb_q <= rb_q + 3'd1;
            end else begin
               row_q <= row_q + 16'd1;
            end
         end
         case (state_q)
            IDLE: begin
               if (fval_rise) begin
                  state_q <= FRAME;
                  sel_q   <= sel;
                  x_q     <= 16'd0;
                  y_q     <= 16'd0;
                  err_q   <= 16'd0;
                  geom_q  <= 1'b0;
                  col_q   <= 16'd0;
                  row_q   <= 16'd0;
                  cb_q    <= 3'd0;
                  rb_q    <= 3'd0;
               end
            end
            FRAME: begin
               if (fval_fall) state_q <= IDLE;
               else if (lval_rise && fval) state_q <= LINE;
            end
            LINE: begin
               if (fval_fall) state_q <= IDLE;
               else if (lval_fall) state_q <= FRAME;
            end
            default: state_q <= IDLE;
         endcase
         // A line still open at fval fall has been folded into lines_d above
         if (fval_fall && (state_q != IDLE)) begin
            meas_lines  <= lines_d;
            pix_err_cnt <= err_q;
            geom_err    <= frame_geom_bad;
            frame_cnt   <= frame_cnt + 16'd1;
            frame_done  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_frame_pattern_checker.sv
`timescale 1ns/1ps
// Directed bench for frame_pattern_checker: frames are generated from a
// pattern model and the expected results are tracked at frame/line level.
module tb_frame_pattern_checker;
   localparam int DH = 32;
   localparam int RC = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        fval;
   logic        lval;
   logic        dval;
   logic [7:0]  pix_value;
   logic [2:0]  sel;
   logic        frame_done;
   logic [15:0] frame_cnt;
   logic [15:0] meas_lines;
   logic [15:0] meas_pixels;
   logic [15:0] pix_err_cnt;
   logic        geom_err;
   logic        proto_err;

   int          total = 0;
   int          bad = 0;
   logic        exp_done;
   logic        exp_geom;
   logic        exp_proto;
   logic [15:0] exp_fcnt;
   logic [15:0] exp_lines;
   logic [15:0] exp_pixels;
   logic [15:0] exp_errs;
   int          m_sel;
   int          m_y;
   int          m_errs;
   int          m_lastw;
   int          inj_x;
   int          inj_y;
   bit          m_geom;
   bit          rand_pix;

   frame_pattern_checker #(.DVAL_HIGH(DH), .ROW_COUNT(RC)) dut (
      .clk         (clk),
      .rst         (rst),
      .fval        (fval),
      .lval        (lval),
      .dval        (dval),
      .pix_value   (pix_value),
      .sel         (sel),
      .frame_done  (frame_done),
      .frame_cnt   (frame_cnt),
      .meas_lines  (meas_lines),
      .meas_pixels (meas_pixels),
      .pix_err_cnt (pix_err_cnt),
      .geom_err    (geom_err),
      .proto_err   (proto_err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] model_pix(input int s, input int x, input int y);
      int cb;
      int rb;
      cb = x / (DH / 8);
      if (cb > 7) cb = 7;
      rb = y / (RC / 8);
      if (rb > 7) rb = 7;
      case (s)
         0:       return 8'h00;
         1:       return 8'hFF;
         3:       return (((cb + rb) % 2) == 1) ? 8'hFF : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   function automatic bit model_cmp(input int s);
      return (s == 0) || (s == 1) || (s == 3);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("frame_done",  {15'd0, frame_done}, {15'd0, exp_done});
      chk("frame_cnt",   frame_cnt,   exp_fcnt);
      chk("meas_lines",  meas_lines,  exp_lines);
      chk("meas_pixels", meas_pixels, exp_pixels);
      chk("pix_err_cnt", pix_err_cnt, exp_errs);
      chk("geom_err",    {15'd0, geom_err},  {15'd0, exp_geom});
      chk("proto_err",   {15'd0, proto_err}, {15'd0, exp_proto});
   end

   task automatic tick();
      @(posedge clk);
      #1;
      exp_done = 1'b0;
   endtask

   task automatic clear_exp();
      exp_done   = 1'b0;
      exp_geom   = 1'b0;
      exp_proto  = 1'b0;
      exp_fcnt   = 16'd0;
      exp_lines  = 16'd0;
      exp_pixels = 16'd0;
      exp_errs   = 16'd0;
   endtask

   task automatic open_frame(input int s, input bit rnd, input int ix, input int iy);
      sel      = 3'(s);
      m_sel    = s;
      m_y      = 0;
      m_errs   = 0;
      m_geom   = 1'b0;
      rand_pix = rnd;
      inj_x    = ix;
      inj_y    = iy;
      fval     = 1'b1;
      tick();
      tick();
   endtask

   task automatic close_line();
      exp_pixels = 16'(m_lastw);
      if (m_lastw != DH) m_geom = 1'b1;
      m_y++;
   endtask

   task automatic send_line(input int w, input bit keep);
      logic [7:0] p;
      lval = 1'b1;
      tick();
      for (int x = 0; x < w; x++) begin
         p = model_pix(m_sel, x, m_y);
         if (rand_pix) p = 8'($urandom_range(0, 255));
         if (x == inj_x && m_y == inj_y) p = ~p;
         if (model_cmp(m_sel) && p != model_pix(m_sel, x, m_y)) m_errs++;
         dval      = 1'b1;
         pix_value = p;
         tick();
      end
      dval    = 1'b0;
      m_lastw = w;
      if (!keep) begin
         lval = 1'b0;
         tick();
         close_line();
         tick();
      end
   endtask

   task automatic close_frame(input bit keep);
      fval = 1'b0;
      tick();
      if (keep) close_line();
      exp_done  = 1'b1;
      exp_fcnt  = exp_fcnt + 16'd1;
      exp_lines = 16'(m_y);
      exp_errs  = (m_errs > 65535) ? 16'hFFFF : 16'(m_errs);
      exp_geom  = m_geom || (m_y != RC);
      lval      = 1'b0;
      tick();
      tick();
   endtask

   task automatic proto_pulse();
      dval      = 1'b1;
      pix_value = 8'h5A;
      tick();
      exp_proto = 1'b1;
      dval      = 1'b0;
      tick();
   endtask

   task automatic run_frame(input int s, input int nlines, input int lastw, input bit rnd,
                            input int ix, input int iy, input bit keep, input bit proto,
                            input int sel_mid);
      open_frame(s, rnd, ix, iy);
      for (int y = 0; y < nlines; y++) begin
         send_line((y == nlines - 1) ? lastw : DH, keep && (y == nlines - 1));
         if (proto && y == 0) proto_pulse();
         if (sel_mid >= 0 && y == nlines / 2) sel = 3'(sel_mid);
      end
      close_frame(keep);
   endtask

   initial begin
      fval = 1'b0; lval = 1'b0; dval = 1'b0; pix_value = 8'h00; sel = 3'd0;
      rst = 1'b1;
      clear_exp();
      tick();
      tick();
      rst = 1'b0;
      tick();

      chk("pin_chk_4_0", {8'h00, model_pix(3, 4, 0)}, 16'h00FF);
      chk("pin_chk_0_2", {8'h00, model_pix(3, 0, 2)}, 16'h00FF);
      chk("pin_chk_0_0", {8'h00, model_pix(3, 0, 0)}, 16'h0000);

      // black frame
      run_frame(0, RC, DH, 1'b0, -1, -1, 1'b0, 1'b0, -1);
      chk("black_cnt", frame_cnt, 16'd1);
      chk("black_err", pix_err_cnt, 16'd0);
      chk("black_lines", meas_lines, 16'd16);
      chk("black_pix", meas_pixels, 16'd32);
      chk("black_geom", {15'd0, geom_err}, 16'd0);

      // checkers with one forced pixel at the first band boundary
      run_frame(3, RC, DH, 1'b0, 4, 0, 1'b0, 1'b0, -1);
      chk("chk_err", pix_err_cnt, 16'd1);
      chk("chk_geom", {15'd0, geom_err}, 16'd0);

      // short frame with a short last line
      run_frame(0, RC - 1, DH - 1, 1'b0, -1, -1, 1'b0, 1'b0, -1);
      chk("short_geom", {15'd0, geom_err}, 16'd1);
      chk("short_lines", meas_lines, 16'd15);
      chk("short_pix", meas_pixels, 16'd31);

      // gradient select: random data, compare disabled; stray dval between lines
      run_frame(2, RC, DH, 1'b1, -1, -1, 1'b0, 1'b1, -1);
      chk("grad_err", pix_err_cnt, 16'd0);
      chk("grad_geom", {15'd0, geom_err}, 16'd0);
      chk("grad_proto", {15'd0, proto_err}, 16'd1);

      // checkers, sel changed mid-frame, fval falls while lval high
      run_frame(3, RC, DH, 1'b0, -1, -1, 1'b1, 1'b0, 1);
      chk("keep_err", pix_err_cnt, 16'd0);
      chk("keep_lines", meas_lines, 16'd16);
      chk("keep_pix", meas_pixels, 16'd32);

      // white frame with a single corrupted pixel
      run_frame(1, RC, DH, 1'b0, 0, 15, 1'b0, 1'b0, -1);
      chk("white_err", pix_err_cnt, 16'd1);
      chk("white_cnt", frame_cnt, 16'd6);

      // reset mid-frame, fval held high through several lines
      open_frame(0, 1'b0, -1, -1);
      for (int y = 0; y < 3; y++) send_line(DH, 1'b0);
      rst = 1'b1;
      clear_exp();
      tick();
      rst = 1'b0;
      tick();
      for (int y = 0; y < 2; y++) begin
         lval = 1'b1;
         tick();
         for (int x = 0; x < DH; x++) begin
            dval = 1'b1;
            tick();
            exp_proto = 1'b1;
         end
         dval = 1'b0;
         lval = 1'b0;
         tick();
      end
      chk("rst_cnt0", frame_cnt, 16'd0);
      fval = 1'b0;
      tick();
      tick();
      run_frame(0, RC, DH, 1'b0, -1, -1, 1'b0, 1'b0, -1);
      chk("rst_cnt1", frame_cnt, 16'd1);
      chk("rst_lines", meas_lines, 16'd16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frame_pattern_checker.md
FRAME_PATTERN_CHECKER -- requirements
Module: frame_pattern_checker

Interface
REQ-001 Parameter DVAL_HIGH, default 640: expected active pixels (dval cycles) per line.
REQ-002 Parameter ROW_COUNT, default 480: expected lines per frame.
REQ-003 clk  input  1: single clock; all logic on rising edge.
REQ-004 rst  input  1: asynchronous, active-high reset.
REQ-005 fval  input  1: frame valid; high for the whole frame.
REQ-006 lval  input  1: line valid; high for the whole line.
REQ-007 dval  input  1: data valid; pixel present this cycle.
REQ-008 pix_value  input  8: pixel data, qualified by dval.
REQ-009 sel  input  3: pattern select; same encoding as the generator.
REQ-010 frame_done  output  1: one-cycle pulse at end of each checked frame.
REQ-011 frame_cnt  output  16: completed frames since reset; wraps.
REQ-012 meas_lines  output  16: lines counted in the last completed frame.
REQ-013 meas_pixels  output  16: dval count of the last completed line.
REQ-014 pix_err_cnt  output  16: pixel mismatches in the last completed frame.
REQ-015 geom_err  output  1: last completed frame had a wrong line count or a wrong line width.
REQ-016 proto_err  output  1: sticky; dval seen with lval or fval low.

Function
REQ-017 The block shall hold fval_d and lval_d registers; rise = input 1 and _d 0; fall = input 0 and _d 1.
REQ-018 The FSM shall have states IDLE, FRAME and LINE.
REQ-019 IDLE->FRAME on fval rise; if fval is already high when reset releases, the block shall stay in IDLE until the next rise.
REQ-020 FRAME->LINE on lval rise while fval is high.
REQ-021 LINE->FRAME on lval fall.
REQ-022 FRAME or LINE->IDLE on fval fall.
REQ-023 On fval rise the block shall capture sel into sel_q and clear the line counter y, the pixel counter x, the working error count and the working geometry flag.
REQ-024 In LINE, each dval=1 cycle shall compare pix_value with the expected value at (x,y), then increment x.
REQ-025 On lval fall the block shall load meas_pixels with x and set the working geometry flag if x != DVAL_HIGH.
REQ-026 On lval fall the block shall increment y and clear x.
REQ-027 Expected values: sel_q 000 -> 8'h00; 001 -> 8'hFF.
REQ-028 sel_q 011: cb = min(x/(DVAL_HIGH/8),7); rb = min(y/(ROW_COUNT/8),7); expected 8'hFF if cb[0]^rb[0], else 8'h00.
REQ-029 For sel_q 010, 100, 101, 110 and 111 the pixel compare shall be disabled; counting and geometry checks still run.
REQ-030 A mismatch shall increment the working error count on the same edge; the count shall saturate at 16'hFFFF.
REQ-031 On fval fall the block shall load meas_lines = y and pix_err_cnt = working count.
REQ-032 On fval fall, geom_err = working geometry flag OR (y != ROW_COUNT).
REQ-033 On fval fall, frame_cnt shall increment and frame_done shall pulse high for exactly the next cycle.
REQ-034 If fval falls while lval is still high, the line shall be closed per REQ-025/026 first, and y shall include that line.
REQ-035 A dval in IDLE or FRAME, or with lval=0, shall not be compared or counted, and shall set proto_err.
REQ-036 sel changes mid-frame shall have no effect until the next fval rise.
REQ-037 Counters x and y shall be 16 bits and shall saturate at 16'hFFFF.

Reset
REQ-038 rst=1 shall force: IDLE; x, y and working registers 0; all outputs 0.
REQ-039 Reset mid-frame shall abort the frame without asserting frame_done.

Verification
REQ-040 Black frame, 640x480 pixels all 8'h00 -> frame_done pulses once; pix_err_cnt=0, meas_lines=480, meas_pixels=640, geom_err=0, frame_cnt=1.
REQ-041 Checkers frame, pixel (x=80,y=0) forced to 8'h00 -> pix_err_cnt=1; pixel (80,0) expects 8'hFF; pixel (0,60) expects 8'hFF; pixel (0,0) expects 8'h00.
REQ-042 Frame of 479 lines, last line 639 pixels -> geom_err=1, meas_lines=479, meas_pixels=639.
REQ-043 Gradient sel=010 with random pixels -> pix_err_cnt=0, geom_err=0.
REQ-044 dval pulse while lval=0 -> proto_err=1, x unchanged.
REQ-045 Reset mid-frame, then fval held high -> no frame_done and frame_cnt=0 until the next full frame; after that frame, frame_cnt=1.
